rv_hazard_ctrl: RTL and testbench

RV_HAZARD_CTRL -- requirements
Module: rv_hazard_ctrl

---
 rtl/rv_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_rv_hazard_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_hazard_ctrl.sv
// In-order pipeline hazard controller: register scoreboard for RAW stalls plus a RUN/FLUSH FSM for taken branches.
// Define RV_HAZARD_PERF_EN to add saturating stall_cnt/flush_cnt performance counters.
module rv_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_id_ir,
   input  logic        if_id_valid,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        br_taken,
   output logic        stall,
   output logic        flush,
   output logic        id_ex_bubble,
   output logic        issue,
   output logic [31:0] scoreboard
`ifdef RV_HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef enum logic {
      RUN,
      FLUSH
   } state_e;

   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] sb_q, sb_d;

   logic [6:0] opcode;
   logic [4:0] rd, rs1, rs2;
   logic       writesRd, readsRs1, readsRs2;
   logic       hazard, inRun;
   logic       unusedIrBits;

   assign opcode       = if_id_ir[6:0];
   assign rd           = if_id_ir[11:7];
   assign rs1          = if_id_ir[19:15];
   assign rs2          = if_id_ir[24:20];
   assign unusedIrBits = ^{if_id_ir[31:25], if_id_ir[14:12]};

   always_comb begin
      writesRd = 1'b0;
      readsRs1 = 1'b0;
      readsRs2 = 1'b0;
      case (opcode)
         7'b0110111, 7'b0010111, 7'b1101111: writesRd = 1'b1;
         7'b1100111, 7'b0000011, 7'b0010011: begin
            writesRd = 1'b1;
            readsRs1 = 1'b1;
         end
         7'b0110011: begin
            writesRd = 1'b1;
            readsRs1 = 1'b1;
            readsRs2 = 1'b1;
         end
         7'b1100011, 7'b0100011: begin
            readsRs1 = 1'b1;
            readsRs2 = 1'b1;
         end
         default: ;
      endcase
   end

   // x0 is never pending because bit 0 of the scoreboard is held at zero.
   assign hazard = (readsRs1 && sb_q[rs1]) || (readsRs2 && sb_q[rs2]);
   assign inRun  = (state_q == RUN);

   // rst gating keeps outputs quiet while reset is held even if br_taken is high.
   assign flush        = rst & (br_taken | (state_q == FLUSH));
   assign stall        = rst & if_id_valid & inRun & hazard & ~br_taken;
   assign issue        = rst & if_id_valid & inRun & ~hazard & ~br_taken;
   assign id_ex_bubble = ~issue;
   assign scoreboard   = sb_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (br_taken) begin
               state_d = FLUSH;
               cnt_d   = FLUSH_RELOAD;
            end
         end
         FLUSH: begin
            if (br_taken) begin
               cnt_d = FLUSH_RELOAD;
            end else if (cnt_q == 3'd0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Set is applied after clear so a new producer wins over an older writeback.
   always_comb begin
      sb_d = sb_q;
      if (wb_valid) begin
         sb_d[wb_rd] = 1'b0;
      end
      if (issue && writesRd) begin
         sb_d[rd] = 1'b1;
      end
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
         sb_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sb_q    <= sb_d;
      end
   end

`ifdef RV_HAZARD_PERF_EN
   logic [31:0] stallCnt_q, flushCnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCnt_q <= 32'd0;
         flushCnt_q <= 32'd0;
      end else begin
         if (stall && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
         end
         if (flush && (flushCnt_q != 32'hFFFF_FFFF)) begin
            flushCnt_q <= flushCnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt = stallCnt_q;
   assign flush_cnt = flushCnt_q;
`endif

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Self-checking bench for rv_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a pending-register / flush-countdown reference model.
module tb_rv_hazard_ctrl;

   localparam int FC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ir;
   logic        valid;
   logic        wbValid;
   logic [4:0]  wbRd;
   logic        brTaken;
   logic        stall, flush, idExBubble, issue;
   logic [31:0] scoreboard;
`ifdef RV_HAZARD_PERF_EN
   logic [31:0] stallCnt, flushCnt;
`endif

   int errors = 0;
   int checks = 0;

   bit          pending[32];
   int          flushRemain;
   logic [3:0]  expCtl;
   logic [31:0] expSb;

   always #5 clk = ~clk;

   rv_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
      .clk(clk),
      .rst(rst),
      .if_id_ir(ir),
      .if_id_valid(valid),
      .wb_valid(wbValid),
      .wb_rd(wbRd),
      .br_taken(brTaken),
      .stall(stall),
      .flush(flush),
      .id_ex_bubble(idExBubble),
      .issue(issue),
      .scoreboard(scoreboard)
`ifdef RV_HAZARD_PERF_EN
      ,
      .stall_cnt(stallCnt),
      .flush_cnt(flushCnt)
`endif
   );

   function automatic bit opWrites(logic [6:0] op);
      case (op)
         7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
         7'b0000011, 7'b0010011, 7'b0110011: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit opReads1(logic [6:0] op);
      case (op)
         7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011,
         7'b0010011, 7'b0110011: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit opReads2(logic [6:0] op);
      case (op)
         7'b1100011, 7'b0100011, 7'b0110011: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] rType(int rd, int rs1, int rs2);
      return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
   endfunction

   function automatic logic [31:0] iType(int rd, int rs1, int imm);
      return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
   endfunction

   // Expected outputs from the current model state and the inputs being driven.
   task automatic predict();
      bit flushing, hazard, doIssue;
      int r1, r2;
      r1       = int'(ir[19:15]);
      r2       = int'(ir[24:20]);
      flushing = (brTaken == 1'b1) || (flushRemain > 0);
      hazard   = (opReads1(ir[6:0]) && r1 != 0 && pending[r1]) ||
                 (opReads2(ir[6:0]) && r2 != 0 && pending[r2]);
      doIssue  = valid && !flushing && !hazard;
      expCtl   = {valid && !flushing && hazard, flushing, doIssue, !doIssue};
      for (int i = 0; i < 32; i++) expSb[i] = pending[i];
   endtask

   task automatic modelUpdate();
      int rd;
      rd = int'(ir[11:7]);
      if (wbValid) pending[wbRd] = 1'b0;
      if (expCtl[1] && opWrites(ir[6:0]) && rd != 0) pending[rd] = 1'b1;
      if (brTaken) flushRemain = FC;
      else if (flushRemain > 0) flushRemain--;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 32; i++) pending[i] = 1'b0;
      flushRemain = 0;
   endtask

   task automatic tick();
      predict();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
   endtask

   task automatic applyReset();
      rst = 1'b0;
      valid = 1'b0; brTaken = 1'b0; wbValid = 1'b0; wbRd = 5'd0; ir = 32'h0000_0013;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; valid = 1'b1; brTaken = 1'b1; wbValid = 1'b1; wbRd = 5'd3;
      ir = rType(6, 5, 5);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({stall, flush, issue, idExBubble} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_ctl c%0d: got %b required 0001", c, {stall, flush, issue, idExBubble});
         end
         checks++;
         if (scoreboard !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_sb c%0d: got %h required 0", c, scoreboard);
         end
      end
      applyReset();
   endtask

   task automatic test_raw_stall();
      logic [3:0] want;
      logic [31:0] wantSb;
      applyReset();
      valid = 1'b1; ir = iType(5, 0, 1);
      #1;
      checks++;
      if ({stall, flush, issue, idExBubble} !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL raw_first_issue: got %b required 0010", {stall, flush, issue, idExBubble});
      end
      tick();
      ir = rType(6, 5, 5);
      for (int c = 0; c < 5; c++) begin
         wbValid = (c == 3); wbRd = 5'd5;
         want   = (c < 4) ? 4'b1001 : 4'b0010;
         wantSb = (c < 4) ? 32'h0000_0020 : 32'h0000_0000;
         #1;
         checks++;
         if ({stall, flush, issue, idExBubble} !== want) begin
            errors++;
            $display("[TB] FAIL raw_ctl c%0d: got %b required %b", c, {stall, flush, issue, idExBubble}, want);
         end
         checks++;
         if (scoreboard !== wantSb) begin
            errors++;
            $display("[TB] FAIL raw_sb c%0d: got %h required %h", c, scoreboard, wantSb);
         end
         tick();
      end
      valid = 1'b0; wbValid = 1'b0;
      #1;
      checks++;
      if (scoreboard !== 32'h0000_0040) begin
         errors++;
         $display("[TB] FAIL raw_consumer_pending: got %h required 00000040", scoreboard);
      end
   endtask

   task automatic test_x0();
      applyReset();
      valid = 1'b1; ir = rType(0, 1, 2);
      tick();
      ir = rType(3, 0, 0);
      #1;
      checks++;
      if ({stall, flush, issue, idExBubble} !== 4'b0010 || scoreboard !== 32'd0) begin
         errors++;
         $display("[TB] FAIL x0_reader: ctl %b sb %h required 0010 sb 0", {stall, flush, issue, idExBubble}, scoreboard);
      end
      tick();
      valid = 1'b0;
      #1;
      checks++;
      if (scoreboard !== 32'h0000_0008) begin
         errors++;
         $display("[TB] FAIL x0_sb: got %h required 00000008", scoreboard);
      end
   endtask

   task automatic test_branch_flush();
      logic [3:0] want;
      applyReset();
      valid = 1'b1; ir = iType(9, 0, 1);
      tick();
      for (int c = 0; c < 4; c++) begin
         brTaken = (c == 0);
         wbValid = (c == 2); wbRd = 5'd9;
         want    = (c < 3) ? 4'b0101 : 4'b0010;
         #1;
         checks++;
         if ({stall, flush, issue, idExBubble} !== want) begin
            errors++;
            $display("[TB] FAIL branch_ctl c%0d: got %b required %b", c, {stall, flush, issue, idExBubble}, want);
         end
         if (c == 3) begin
            checks++;
            if (scoreboard !== 32'd0) begin
               errors++;
               $display("[TB] FAIL branch_wb_clear: got %h required 0", scoreboard);
            end
         end
         tick();
      end
      wbValid = 1'b0; valid = 1'b0;
   endtask

   task automatic test_set_wins();
      applyReset();
      valid = 1'b1; ir = iType(7, 0, 1);
      tick();
      ir = iType(7, 0, 2); wbValid = 1'b1; wbRd = 5'd7;
      #1;
      checks++;
      if ({stall, flush, issue, idExBubble} !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL setwins_issue: got %b required 0010", {stall, flush, issue, idExBubble});
      end
      tick();
      valid = 1'b0; wbValid = 1'b0;
      #1;
      checks++;
      if (scoreboard !== 32'h0000_0080) begin
         errors++;
         $display("[TB] FAIL setwins_sb: got %h required 00000080", scoreboard);
      end
   endtask

   task automatic test_reset_mid_op();
      applyReset();
      valid = 1'b1; ir = iType(5, 0, 1);
      tick();
      ir = iType(6, 0, 1);
      tick();
      ir = rType(7, 5, 6);
      #1;
      checks++;
      if ({stall, flush, issue, idExBubble} !== 4'b1001 || scoreboard !== 32'h0000_0060) begin
         errors++;
         $display("[TB] FAIL midstall_pre: ctl %b sb %h required 1001 sb 00000060", {stall, flush, issue, idExBubble}, scoreboard);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({stall, flush, issue, idExBubble} !== 4'b0001 || scoreboard !== 32'd0) begin
         errors++;
         $display("[TB] FAIL midstall_async: ctl %b sb %h required 0001 sb 0", {stall, flush, issue, idExBubble}, scoreboard);
      end
      modelReset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      predict();
      checks++;
      if ({stall, flush, issue, idExBubble} !== expCtl) begin
         errors++;
         $display("[TB] FAIL midstall_after: got %b required %b", {stall, flush, issue, idExBubble}, expCtl);
      end
      tick();
      valid = 1'b0; brTaken = 1'b1;
      tick();
      brTaken = 1'b0;
      #3 rst = 1'b0;
      #1;
      checks++;
      if (flush !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midflush_async: flush %b required 0", flush);
      end
      modelReset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({stall, flush, issue, idExBubble} !== 4'b0001 || scoreboard !== 32'd0) begin
         errors++;
         $display("[TB] FAIL midflush_after: ctl %b sb %h required 0001 sb 0", {stall, flush, issue, idExBubble}, scoreboard);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops[9];
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
              7'b0010011, 7'b0110011, 7'b1100011, 7'b0100011};
      applyReset();
      for (int c = 0; c < 400; c++) begin
         ir        = $urandom;
         ir[6:0]   = ($urandom_range(0, 9) == 9) ? 7'b1110011 : ops[$urandom_range(0, 8)];
         ir[11:7]  = 5'($urandom_range(0, 7));
         ir[19:15] = 5'($urandom_range(0, 7));
         ir[24:20] = 5'($urandom_range(0, 7));
         valid     = ($urandom_range(0, 3) != 0);
         brTaken   = ($urandom_range(0, 9) == 0);
         wbValid   = ($urandom_range(0, 2) == 0);
         wbRd      = 5'($urandom_range(0, 7));
         #1;
         predict();
         checks++;
         if ({stall, flush, issue, idExBubble} !== expCtl) begin
            errors++;
            $display("[TB] FAIL rand_ctl c%0d: got %b required %b", c, {stall, flush, issue, idExBubble}, expCtl);
         end
         checks++;
         if (scoreboard !== expSb) begin
            errors++;
            $display("[TB] FAIL rand_sb c%0d: got %h required %h", c, scoreboard, expSb);
         end
         tick();
      end
      valid = 1'b0; brTaken = 1'b0; wbValid = 1'b0;
   endtask

`ifdef RV_HAZARD_PERF_EN
   task automatic test_perf();
      applyReset();
      valid = 1'b1; ir = iType(5, 0, 1);
      tick();
      ir = rType(6, 5, 5);
      for (int c = 0; c < 5; c++) tick();
      valid = 1'b0; brTaken = 1'b1;
      tick();
      brTaken = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      #1;
      checks++;
      if (stallCnt !== 32'd5 || flushCnt !== 32'd3) begin
         errors++;
         $display("[TB] FAIL perf_counts: stall_cnt %0d flush_cnt %0d required 5 and 3", stallCnt, flushCnt);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b0; valid = 1'b0; brTaken = 1'b0; wbValid = 1'b0; wbRd = 5'd0; ir = 32'h0000_0013;
      modelReset();
      test_reset();
      test_raw_stall();
      test_x0();
      test_branch_flush();
      test_set_wins();
      test_reset_mid_op();
      test_random();
`ifdef RV_HAZARD_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
